// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg: shared game-flow state type, keycodes and fade scaling helper.
// Rev 1.0
// ============================================================================
package game_pkg;

  typedef enum logic [2:0] {
    TITLE          = 3'd0,
    ROAM           = 3'd1,
    FADE_TO_BATTLE = 3'd2,
    BATTLE         = 3'd3,
    FADE_TO_ROAM   = 3'd4,
    CHAMPION       = 3'd5,
    DEFEAT         = 3'd6
  } game_state_t;

  // USB HID keycodes
  localparam logic [7:0] W     = 8'h1A;
  localparam logic [7:0] A     = 8'h04;
  localparam logic [7:0] S     = 8'h16;
  localparam logic [7:0] D     = 8'h07;
  localparam logic [7:0] ENTER = 8'h28;

  localparam int NUM_BATTLES_DEFAULT = 5;

  // Map a fade count onto the 0..15 brightness scale, truncating.
  function automatic logic [3:0] fade_scale(input logic [3:0] count, input int frames);
    int scaled;
    scaled = (int'(count) * 15) / (frames - 1);
    return scaled[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
// frame_tick_gen: 2-flop synchroniser plus registered rising-edge pulse.
// Rev 1.0
// ============================================================================
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_tick
);

  logic r_sync1, r_sync2, r_prev, r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_tick  <= r_sync2 & ~r_prev;
    end
  end

  assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/battle_sequencer.sv
`default_nettype none
// ============================================================================
// battle_sequencer: Elite Four game-flow FSM (title/roam/battle/fades/end).
// Optional fade counter enabled by BATTLE_SEQUENCER_FADE_EN. Rev 1.0
// ============================================================================
module battle_sequencer #(
  parameter int         NUM_BATTLES = game_pkg::NUM_BATTLES_DEFAULT,
  parameter int         FADE_FRAMES = 16,
  parameter logic [7:0] ENTER       = 8'h28
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       start_battle,
  input  logic       battle_won,
  input  logic       battle_lost,
  output logic       is_roam,
  output logic       is_battle,
  output logic [2:0] cur_battle,
  output logic [3:0] fade_level,
  output logic       champion,
  output logic       game_over
);
  import game_pkg::*;

  localparam logic [2:0] LAST_BATTLE = 3'(NUM_BATTLES - 1);

  if (FADE_FRAMES < 2 || FADE_FRAMES > 16) begin : g_bad_fade_frames
    $error("battle_sequencer: FADE_FRAMES must be in 2..16");
  end

  logic        w_frame_tick, w_enter_now, w_in_fade, w_fade_end;
  logic        r_key_was_enter, r_enter_tick, r_start, r_won, r_lost;
  game_state_t r_state, w_next;
  logic [2:0]  r_cur, w_cur_next;
  logic [3:0]  w_level_next, r_fade_level;
  logic        r_is_roam, r_is_battle, r_champion, r_game_over;

  frame_tick_gen u_frame_tick (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .i_async (frame_clk),
    .o_tick  (w_frame_tick)
  );

  assign w_enter_now = (keycode == ENTER);

  // Input stage: every control input acts one cycle after it is sampled.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_key_was_enter <= 1'b0;
      r_enter_tick    <= 1'b0;
      r_start         <= 1'b0;
      r_won           <= 1'b0;
      r_lost          <= 1'b0;
    end else begin
      r_key_was_enter <= w_enter_now;
      r_enter_tick    <= w_enter_now & ~r_key_was_enter;
      r_start         <= start_battle;
      r_won           <= battle_won;
      r_lost          <= battle_lost;
    end
  end

  assign w_in_fade = (r_state == FADE_TO_BATTLE) || (r_state == FADE_TO_ROAM);

`ifdef BATTLE_SEQUENCER_FADE_EN
  localparam logic [3:0] FADE_LAST = 4'(FADE_FRAMES - 1);

  logic [3:0] r_fade_cnt, w_cnt_next;

  assign w_fade_end = w_frame_tick && (r_fade_cnt == FADE_LAST);

  always_comb begin
    w_cnt_next = 4'd0;
    if (w_in_fade && !w_fade_end)
      w_cnt_next = w_frame_tick ? r_fade_cnt + 4'd1 : r_fade_cnt;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_fade_cnt <= 4'd0;
    else          r_fade_cnt <= w_cnt_next;
  end

  assign w_level_next = (w_next == FADE_TO_BATTLE || w_next == FADE_TO_ROAM)
                      ? fade_scale(w_cnt_next, FADE_FRAMES) : 4'd0;
`else
  assign w_fade_end   = w_frame_tick;
  assign w_level_next = 4'd0;
`endif

  // Loss is tested before win so a simultaneous pair always ends in DEFEAT.
  always_comb begin
    w_next     = r_state;
    w_cur_next = r_cur;
    case (r_state)
      TITLE:          if (r_enter_tick) w_next = ROAM;
      ROAM:           if (r_start)      w_next = FADE_TO_BATTLE;
      FADE_TO_BATTLE: if (w_fade_end)   w_next = BATTLE;
      BATTLE: begin
        if (r_lost) begin
          w_next = DEFEAT;
        end else if (r_won) begin
          if (r_cur == LAST_BATTLE) begin
            w_next = CHAMPION;
          end else begin
            w_next     = FADE_TO_ROAM;
            w_cur_next = r_cur + 3'd1;
          end
        end
      end
      FADE_TO_ROAM:   if (w_fade_end)   w_next = ROAM;
      CHAMPION, DEFEAT: begin
        if (r_enter_tick) begin
          w_next     = TITLE;
          w_cur_next = 3'd0;
        end
      end
      default:        w_next = TITLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= TITLE;
      r_cur        <= 3'd0;
      r_is_roam    <= 1'b0;
      r_is_battle  <= 1'b0;
      r_champion   <= 1'b0;
      r_game_over  <= 1'b0;
      r_fade_level <= 4'd0;
    end else begin
      r_state      <= w_next;
      r_cur        <= w_cur_next;
      r_is_roam    <= (w_next == ROAM);
      r_is_battle  <= (w_next == BATTLE);
      r_champion   <= (w_next == CHAMPION);
      r_game_over  <= (w_next == DEFEAT);
      r_fade_level <= w_level_next;
    end
  end

  assign is_roam    = r_is_roam;
  assign is_battle  = r_is_battle;
  assign cur_battle = r_cur;
  assign fade_level = r_fade_level;
  assign champion   = r_champion;
  assign game_over  = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_battle_sequencer.sv
`default_nettype none
// ============================================================================
// tb_battle_sequencer: directed + randomized bench with a game-level model.
// Rev 1.0
// ============================================================================
module tb_battle_sequencer;

  localparam int         NB       = 5;
  localparam int         FF       = 16;
  localparam logic [7:0] KC_ENTER = 8'h28;
`ifdef BATTLE_SEQUENCER_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif

  // model screen codes
  localparam int M_TITLE = 0, M_ROAM = 1, M_FTB = 2, M_BATTLE = 3,
                 M_FTR = 4, M_CHAMP = 5, M_DEFEAT = 6;

  logic       Clk, Reset_n, frame_clk, start_battle, battle_won, battle_lost;
  logic [7:0] keycode;
  logic       is_roam, is_battle, champion, game_over;
  logic [2:0] cur_battle;
  logic [3:0] fade_level;

  battle_sequencer #(.NUM_BATTLES(NB), .FADE_FRAMES(FF), .ENTER(KC_ENTER)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .keycode      (keycode),
    .start_battle (start_battle),
    .battle_won   (battle_won),
    .battle_lost  (battle_lost),
    .is_roam      (is_roam),
    .is_battle    (is_battle),
    .cur_battle   (cur_battle),
    .fade_level   (fade_level),
    .champion     (champion),
    .game_over    (game_over)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int m_st, m_cur, m_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_in_fade();
    return (m_st == M_FTB) || (m_st == M_FTR);
  endfunction

  function automatic int m_level();
    if (!FADE_EN || !m_in_fade()) return 0;
    return (m_cnt * 15) / (FF - 1);
  endfunction

  task automatic m_reset();
    m_st = M_TITLE; m_cur = 0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".is_roam"},    32'(is_roam),    32'(m_st == M_ROAM));
    check_val({tag, ".is_battle"},  32'(is_battle),  32'(m_st == M_BATTLE));
    check_val({tag, ".champion"},   32'(champion),   32'(m_st == M_CHAMP));
    check_val({tag, ".game_over"},  32'(game_over),  32'(m_st == M_DEFEAT));
    check_val({tag, ".cur_battle"}, 32'(cur_battle), 32'(m_cur));
    check_val({tag, ".fade_level"}, 32'(fade_level), 32'(m_level()));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_enter(input int hold);
    keycode = KC_ENTER; tick(hold);
    keycode = 8'h00;    tick(4);
    if (m_st == M_TITLE) m_st = M_ROAM;
    else if (m_st == M_CHAMP || m_st == M_DEFEAT) begin m_st = M_TITLE; m_cur = 0; end
  endtask

  task automatic do_other_key(input int hold);
    logic [7:0] k;
    k = 8'($urandom_range(1, 255));
    if (k == KC_ENTER) k = 8'h04;
    keycode = k; tick(hold);
    keycode = 8'h00; tick(2);
  endtask

  task automatic do_start(input int hold);
    start_battle = 1'b1; tick(hold);
    start_battle = 1'b0; tick(4);
    if (m_st == M_ROAM) begin m_st = M_FTB; m_cnt = 0; end
  endtask

  task automatic do_result(input bit won, input bit lost);
    battle_won = won; battle_lost = lost; tick(1);
    battle_won = 1'b0; battle_lost = 1'b0; tick(4);
    if (m_st == M_BATTLE) begin
      if (lost) m_st = M_DEFEAT;
      else if (won) begin
        if (m_cur == NB - 1) m_st = M_CHAMP;
        else begin m_st = M_FTR; m_cur++; m_cnt = 0; end
      end
    end
  endtask

  task automatic do_frame();
    frame_clk = 1'b1; tick(5);
    frame_clk = 1'b0; tick(3);
    if (m_in_fade()) begin
      if (FADE_EN && m_cnt < FF - 1) m_cnt++;
      else begin
        m_cnt = 0;
        m_st  = (m_st == M_FTB) ? M_BATTLE : M_ROAM;
      end
    end
  endtask

  task automatic run_fade(input string tag);
    for (int i = 0; i < FF + 2 && m_in_fade(); i++) begin
      do_frame();
      check_outputs($sformatf("%s%0d", tag, i));
    end
  endtask

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; keycode = 8'h00;
    start_battle = 1'b0; battle_won = 1'b0; battle_lost = 1'b0;
    m_reset();
    tick(3);
    check_outputs("reset");
    Reset_n = 1'b1;
    tick(2);
    check_outputs("reset_rel");

    // ENTER held for a long time: a single TITLE->ROAM step
    keycode = KC_ENTER; tick(1000);
    m_st = M_ROAM;
    check_outputs("enter_hold");
    keycode = 8'h00; tick(4);
    check_outputs("enter_rel");

    // is_roam drops exactly one cycle after start_battle is sampled
    start_battle = 1'b1; tick(1);
    check_val("lat.is_roam_pre", 32'(is_roam), 32'd1);
    start_battle = 1'b0; tick(1);
    check_val("lat.is_roam_post", 32'(is_roam), 32'd0);
    m_st = M_FTB; m_cnt = 0;
    tick(3);
    check_outputs("fade_entry");
    run_fade("fade");
    check_val("fade_done.is_battle", 32'(is_battle), 32'd1);

    // Win all battles in turn
    for (int b = 0; b < NB; b++) begin
      if (b > 0) begin do_start(1); run_fade($sformatf("tb%0d_", b)); end
      do_result(1'b1, 1'b0);
      check_outputs($sformatf("win%0d", b));
      if (b < NB - 1) run_fade($sformatf("tr%0d_", b));
    end
    check_val("champ.flag", 32'(champion), 32'd1);
    check_val("champ.cur", 32'(cur_battle), 32'(NB - 1));
    do_enter(3);
    check_outputs("champ_exit");

    // Simultaneous win+loss at index 2 ends in defeat
    do_enter(2);
    for (int b = 0; b < 2; b++) begin
      do_start(1); run_fade("d_tb");
      do_result(1'b1, 1'b0); run_fade("d_tr");
    end
    do_start(2); run_fade("d_final");
    do_result(1'b1, 1'b1);
    check_outputs("both");
    check_val("both.game_over", 32'(game_over), 32'd1);
    check_val("both.cur", 32'(cur_battle), 32'd2);
    do_enter(2);
    check_outputs("defeat_exit");

    // Inputs outside their screen are ignored
    do_start(2);           check_outputs("gate_start_title");
    do_enter(1);           check_outputs("gate_roam");
    do_result(1'b1, 1'b0); check_outputs("gate_won_roam");
    do_result(1'b0, 1'b1); check_outputs("gate_lost_roam");

    // Asynchronous reset partway through a fade
    do_start(1);
    for (int i = 0; i < 7 && m_in_fade(); i++) do_frame();
    check_outputs("pre_reset");
    #2 Reset_n = 1'b0;
    #1 m_reset();
    check_outputs("async_reset");
    tick(2);
    Reset_n = 1'b1;
    tick(2);
    check_outputs("post_reset");

    // Randomized play
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 12)      do_enter(int'($urandom_range(1, 20)));
      else if (r < 27) do_start(int'($urandom_range(1, 3)));
      else if (r < 62) do_frame();
      else if (r < 80) do_result(1'b1, 1'b0);
      else if (r < 83) do_result(1'b0, 1'b1);
      else if (r < 85) do_result(1'b1, 1'b1);
      else if (r < 93) do_other_key(int'($urandom_range(1, 5)));
      else             tick(int'($urandom_range(1, 6)));
      check_outputs($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/battle_sequencer.md
# battle_sequencer

Top-level game-flow controller for the Elite Four adventure. It sequences the roam screen and the battle engine, and owns the `cur_battle` index (0–4) that selects which elite sprite is drawn. It consumes `start_battle` from the roam block and win/loss pulses from the battle engine. It produces `is_roam`, `is_battle`, a per-frame screen-fade level and the end-of-game flags consumed by the colour mapper.

## Interface
- `NUM_BATTLES`, default 5: number of elite battles; the last index is `NUM_BATTLES-1`.
- `FADE_FRAMES`, default 16: frames per fade transition; legal range 2–16.
- `ENTER`, default 8'h28: keycode that advances the title and end screens.

Ports (clock and reset first):
- `Clk` in 1: system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_clk` in 1: vertical-sync-rate frame clock, asynchronous to `Clk`.
- `keycode` in 8: current keyboard keycode.
- `start_battle` in 1: level from the roam block; high while ENTER is pressed facing the elite.
- `battle_won` in 1: one-`Clk` pulse from the battle engine.
- `battle_lost` in 1: one-`Clk` pulse from the battle engine.
- `is_roam` out 1: roam screen active; low resets the trainer position in the roam block.
- `is_battle` out 1: battle engine enabled.
- `cur_battle` out 3: current elite index, 0..`NUM_BATTLES-1`.
- `fade_level` out 4: 0 = full brightness, 15 = black.
- `champion` out 1: all battles won.
- `game_over` out 1: a battle was lost.

## Operation
Frame edge:
- `frame_clk` passes through a 2-flop synchroniser, then a rising-edge detector.
- The result, `frame_tick`, is a one-`Clk` pulse.

Enter edge:
- `enter_tick` pulses one cycle when `keycode==ENTER` and the previous cycle's keycode was not ENTER.
- A held ENTER therefore never advances two screens.

State machine (`game_state_t`):
- TITLE: on `enter_tick`, go to ROAM.
- ROAM: on `start_battle`, go to FADE_TO_BATTLE.
- FADE_TO_BATTLE: fade runs; at fade end, go to BATTLE.
- BATTLE:
  - `battle_lost` → DEFEAT.
  - Otherwise, `battle_won` with `cur_battle==NUM_BATTLES-1` → CHAMPION.
  - Otherwise, `battle_won` → FADE_TO_ROAM, and `cur_battle` increments.
- FADE_TO_ROAM: at fade end, go to ROAM.
- CHAMPION, DEFEAT: on `enter_tick`, go to TITLE and clear `cur_battle` to 0.

Input gating:
- `start_battle` is ignored outside ROAM.
- `battle_won` and `battle_lost` are ignored outside BATTLE.
- If `battle_won` and `battle_lost` arrive in the same cycle, loss has priority.

Fade counter:
- Counts only in the FADE_* states and advances only on `frame_tick`.
- Fade end is `frame_tick` while the count equals `FADE_FRAMES-1`; the counter then returns to 0.

`fade_level` (registered):
- `count*15/(FADE_FRAMES-1)`, truncated.
- 0 outside the FADE_* states.

Output decode:
- `is_roam` = ROAM, `is_battle` = BATTLE, `champion` = CHAMPION, `game_over` = DEFEAT.
- All outputs are registered, decoded from the next state.

## Timing
- Reset values: state TITLE; `is_roam`, `is_battle`, `champion`, `game_over` = 0; `cur_battle` = 0; `fade_level` = 0; fade count 0.
- `frame_clk` rising edge to `frame_tick`: 3 `Clk` cycles.
- Input (`start_battle`, `battle_won`, `battle_lost`, `enter_tick`) sampled high at edge N:
  - The new state and all outputs are visible after edge N+1.
  - `is_roam` therefore falls one cycle after `start_battle` is sampled.
- `cur_battle` updates in the same cycle as entry to FADE_TO_ROAM. It is stable throughout every fade and every BATTLE.
- Fade duration: exactly `FADE_FRAMES` `frame_tick`s; the first tick counts from entry.
- Asserting `Reset_n` mid-fade or mid-battle returns immediately to the reset values, with no clock required.

## Configuration
- `BATTLE_SEQUENCER_FADE_EN` defined:
  - Fade counter and `fade_level` operate as above.
- `BATTLE_SEQUENCER_FADE_EN` undefined:
  - The fade counter is removed and `fade_level` is tied to 0.
  - Each FADE_* state lasts until the first `frame_tick`, then exits.

## Structure
- Package `game_pkg`:
  - `game_state_t` enum (3 bits: TITLE, ROAM, FADE_TO_BATTLE, BATTLE, FADE_TO_ROAM, CHAMPION, DEFEAT).
  - Keycode constants W, A, S, D, ENTER.
  - `NUM_BATTLES_DEFAULT`.
- Sub-module `frame_tick_gen`: synchroniser plus rising-edge pulse, reusable by the roam block.

## Test plan
- Reset, then ENTER held for 1000 cycles → exactly one TITLE→ROAM transition; `is_roam=1`; `cur_battle=0`.
- ROAM, `start_battle` pulse, 16 frame ticks → `fade_level` steps 0,1,2,…,15 (`FADE_FRAMES=16`); `is_battle=1` after the 16th tick; `is_roam=0` one cycle after `start_battle`.
- Five BATTLE cycles, each with a `battle_won` pulse → `cur_battle` 0→1→2→3→4; after the fifth win, `champion=1` and `cur_battle` stays 4; ENTER edge → TITLE with `cur_battle=0`.
- BATTLE with `battle_won` and `battle_lost` in the same cycle at `cur_battle=2` → DEFEAT; `game_over=1`; `cur_battle` stays 2.
- `start_battle` in TITLE, `battle_won` in ROAM → no state change.
- `Reset_n` low mid-fade (count 7) → all outputs at reset values within the same cycle.
- Build with `BATTLE_SEQUENCER_FADE_EN` undefined → `fade_level` always 0; BATTLE is entered on the first `frame_tick` after `start_battle`.
